// File: rtl/xfer_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xfer_pkg
//  Description : Shared definitions for the transfer register bank: byte
//                width, lane bit-offset helper and the per-register
//                operation encoding (highest-priority operation wins).
//  Optional    : XFER_SHADOW_EN (consumed by xfer_reg_cell)
//  Revision    : 1.0 - initial release
// ============================================================================
package xfer_pkg;

    localparam int BYTE_W = 8;

    // Operation selected for one register in one cycle, after priority.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_XFER = 3'd1,
        OP_BYTE = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } op_e;

    // Bit position of the least significant bit of a byte lane.
    function automatic int lane_lsb(input int lane);
        return lane * BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xfer_reg_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : xfer_reg_bank_if
//  Description : Bus bundle of the transfer register bank.
//                master : drives loads, inc/dec and read selects
//                slave  : the register bank (returns RegOut, MainBusOut, wrap)
//  Ports       : xfer_load_n/xfer_sel/XferBusIn    transfer-bus load
//                main_load_n/main_sel/main_lane/MainBusIn  byte load
//                inc_n/dec_n/step_sel               increment / decrement
//                out_sel -> RegOut                  full-width read
//                rd_sel/rd_lane -> MainBusOut       byte read-back
//                wrap                               inc/dec wrap pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface xfer_reg_bank_if
    import xfer_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W  = $clog2(NUM_REGS);
    localparam int LANE_W = $clog2(DATA_W / BYTE_W);

    logic                xfer_load_n;
    logic [SEL_W-1:0]    xfer_sel;
    logic [DATA_W-1:0]   XferBusIn;
    logic                main_load_n;
    logic [SEL_W-1:0]    main_sel;
    logic [LANE_W-1:0]   main_lane;
    logic [BYTE_W-1:0]   MainBusIn;
    logic                inc_n;
    logic                dec_n;
    logic [SEL_W-1:0]    step_sel;
    logic [SEL_W-1:0]    out_sel;
    logic [DATA_W-1:0]   RegOut;
    logic [SEL_W-1:0]    rd_sel;
    logic [LANE_W-1:0]   rd_lane;
    logic [BYTE_W-1:0]   MainBusOut;
    logic                wrap;

    modport master (
        output xfer_load_n, xfer_sel, XferBusIn,
        output main_load_n, main_sel, main_lane, MainBusIn,
        output inc_n, dec_n, step_sel,
        output out_sel, rd_sel, rd_lane,
        input  RegOut, MainBusOut, wrap
    );

    modport slave (
        input  xfer_load_n, xfer_sel, XferBusIn,
        input  main_load_n, main_sel, main_lane, MainBusIn,
        input  inc_n, dec_n, step_sel,
        input  out_sel, rd_sel, rd_lane,
        output RegOut, MainBusOut, wrap
    );

endinterface
`default_nettype wire

// File: rtl/xfer_reg_bank_cell.sv
`default_nettype none
// ============================================================================
//  Module      : xfer_reg_cell
//  Description : One transfer register. Priority xfer > byte > inc/dec,
//                byte-lane write, modular inc/dec and wrap detection.
//  Optional    : XFER_SHADOW_EN - lower lanes are staged in a shadow and
//                committed together with the top lane.
//  Ports       : clk, rst_n (sync, active low)
//                xfer_en/xfer_data      whole-register load
//                byte_en/lane/byte_data byte-lane load
//                inc_en/dec_en          step request
//                q                      register contents
//                wrap_hit               an executing step wraps this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module xfer_reg_cell
    import xfer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              xfer_en,
    input  wire logic [DATA_W-1:0] xfer_data,
    input  wire logic              byte_en,
    input  wire logic [LANE_W-1:0] lane,
    input  wire logic [BYTE_W-1:0] byte_data,
    input  wire logic              inc_en,
    input  wire logic              dec_en,
    output logic      [DATA_W-1:0] q,
    output logic                   wrap_hit
);
    localparam int NUM_LANES = DATA_W / BYTE_W;
    localparam int TOP_LANE  = NUM_LANES - 1;

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_next_q;
    logic              w_lane_ok;
    op_e               w_op;

`ifdef XFER_SHADOW_EN
    logic [DATA_W-BYTE_W-1:0] r_shadow;
    logic [DATA_W-BYTE_W-1:0] w_next_shadow;
`endif

    // Lane indices past the last byte (non power-of-two lane count) are
    // treated as no byte request at all.
    assign w_lane_ok = (int'(lane) < NUM_LANES);

    always_comb begin
        w_op = OP_NONE;
        if (xfer_en)
            w_op = OP_XFER;
        else if (byte_en && w_lane_ok)
            w_op = OP_BYTE;
        else if (inc_en && !dec_en)
            w_op = OP_INC;
        else if (dec_en && !inc_en)
            w_op = OP_DEC;
    end

    always_comb begin
        w_next_q = r_q;
`ifdef XFER_SHADOW_EN
        w_next_shadow = r_shadow;
`endif
        case (w_op)
            OP_XFER: begin
                w_next_q = xfer_data;
`ifdef XFER_SHADOW_EN
                w_next_shadow = '0;
`endif
            end
            OP_BYTE: begin
`ifdef XFER_SHADOW_EN
                // Top lane commits the staged lower lanes atomically.
                if (lane == LANE_W'(TOP_LANE)) begin
                    w_next_q = {byte_data, r_shadow};
                end else begin
                    for (int l = 0; l < TOP_LANE; l++) begin
                        if (lane == LANE_W'(l))
                            w_next_shadow[lane_lsb(l) +: BYTE_W] = byte_data;
                    end
                end
`else
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (lane == LANE_W'(l))
                        w_next_q[lane_lsb(l) +: BYTE_W] = byte_data;
                end
`endif
            end
            OP_INC:  w_next_q = r_q + DATA_W'(1);
            OP_DEC:  w_next_q = r_q - DATA_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
`ifdef XFER_SHADOW_EN
            r_shadow <= '0;
`endif
        end else begin
            r_q <= w_next_q;
`ifdef XFER_SHADOW_EN
            r_shadow <= w_next_shadow;
`endif
        end
    end

    assign q        = r_q;
    assign wrap_hit = ((w_op == OP_INC) && (&r_q)) ||
                      ((w_op == OP_DEC) && (r_q == '0));

endmodule
`default_nettype wire

// File: rtl/xfer_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : xfer_reg_bank
//  Description : Bank of NUM_REGS transfer registers between the 8-bit main
//                bus and the DATA_W transfer bus. Select decode, read muxes
//                and the registered wrap pulse live here; per-register
//                behaviour lives in xfer_reg_cell.
//  Optional    : XFER_SHADOW_EN - atomic multi-byte loads via shadow lanes
//  Ports       : clk, rst_n (sync, active low)
//                bus : xfer_reg_bank_if.slave (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module xfer_reg_bank
    import xfer_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    xfer_reg_bank_if.slave bus
);
    localparam int SEL_W     = $clog2(NUM_REGS);
    localparam int LANE_W    = $clog2(DATA_W / BYTE_W);
    localparam int NUM_LANES = DATA_W / BYTE_W;

    logic [DATA_W-1:0]   w_q [NUM_REGS];
    logic [NUM_REGS-1:0] w_wrap_hit;
    logic [DATA_W-1:0]   w_reg_out;
    logic [DATA_W-1:0]   w_rd_word;
    logic [BYTE_W-1:0]   w_main_out;
    logic                r_wrap;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
            xfer_reg_cell #(
                .DATA_W (DATA_W),
                .LANE_W (LANE_W)
            ) u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .xfer_en   (!bus.xfer_load_n && (bus.xfer_sel == SEL_W'(i))),
                .xfer_data (bus.XferBusIn),
                .byte_en   (!bus.main_load_n && (bus.main_sel == SEL_W'(i))),
                .lane      (bus.main_lane),
                .byte_data (bus.MainBusIn),
                .inc_en    (!bus.inc_n && (bus.step_sel == SEL_W'(i))),
                .dec_en    (!bus.dec_n && (bus.step_sel == SEL_W'(i))),
                .q         (w_q[i]),
                .wrap_hit  (w_wrap_hit[i])
            );
        end
    endgenerate

    // Compare-based muxes so selects beyond NUM_REGS / lanes read as zero.
    always_comb begin
        w_reg_out = '0;
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.out_sel == SEL_W'(i)) w_reg_out = w_q[i];
            if (bus.rd_sel  == SEL_W'(i)) w_rd_word = w_q[i];
        end
    end

    always_comb begin
        w_main_out = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (bus.rd_lane == LANE_W'(l))
                w_main_out = w_rd_word[lane_lsb(l) +: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wrap <= 1'b0;
        else
            r_wrap <= |w_wrap_hit;
    end

    assign bus.RegOut     = w_reg_out;
    assign bus.MainBusOut = w_main_out;
    assign bus.wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_xfer_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xfer_reg_bank
//  Description : Self-checking bench for xfer_reg_bank (DATA_W=16,
//                NUM_REGS=4): directed scenarios followed by randomized
//                operations, compared against a behavioural model.
//  Optional    : XFER_SHADOW_EN - model and directed order follow the build
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xfer_reg_bank;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 4;

    logic clk;
    logic rst_n;

    xfer_reg_bank_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();

    xfer_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: register values, expected wrap, staged lower bytes.
    logic [15:0] m_reg [NUM_REGS];
    logic [15:0] n_reg [NUM_REGS];
    logic        m_wrap;
    logic        n_wrap;
`ifdef XFER_SHADOW_EN
    logic [7:0]  m_shadow [NUM_REGS];
    logic [7:0]  n_shadow [NUM_REGS];
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst_n           = 1'b1;
        bus.xfer_load_n = 1'b1;
        bus.main_load_n = 1'b1;
        bus.inc_n       = 1'b1;
        bus.dec_n       = 1'b1;
    endtask

    task automatic op_xfer(input int sel, input logic [15:0] data);
        bus.xfer_load_n = 1'b0;
        bus.xfer_sel    = 2'(sel);
        bus.XferBusIn   = data;
    endtask

    task automatic op_byte(input int sel, input int lane, input logic [7:0] data);
        bus.main_load_n = 1'b0;
        bus.main_sel    = 2'(sel);
        bus.main_lane   = 1'(lane);
        bus.MainBusIn   = data;
    endtask

    task automatic op_step(input int sel, input bit inc, input bit dec);
        bus.inc_n    = ~inc;
        bus.dec_n    = ~dec;
        bus.step_sel = 2'(sel);
    endtask

    // Next state from the behavioural rules: reset beats all; per register
    // transfer load, then byte load, then a lone inc or dec.
    task automatic model_step();
        n_wrap = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            n_reg[r] = m_reg[r];
`ifdef XFER_SHADOW_EN
            n_shadow[r] = m_shadow[r];
`endif
            if (!rst_n) begin
                n_reg[r] = 16'h0000;
`ifdef XFER_SHADOW_EN
                n_shadow[r] = 8'h00;
`endif
            end else if (!bus.xfer_load_n && int'(bus.xfer_sel) == r) begin
                n_reg[r] = bus.XferBusIn;
`ifdef XFER_SHADOW_EN
                n_shadow[r] = 8'h00;
`endif
            end else if (!bus.main_load_n && int'(bus.main_sel) == r) begin
`ifdef XFER_SHADOW_EN
                if (bus.main_lane == 1'b1)
                    n_reg[r] = {bus.MainBusIn, m_shadow[r]};
                else
                    n_shadow[r] = bus.MainBusIn;
`else
                n_reg[r][8*int'(bus.main_lane) +: 8] = bus.MainBusIn;
`endif
            end else if (int'(bus.step_sel) == r && (bus.inc_n != bus.dec_n)) begin
                if (!bus.inc_n) begin
                    if (m_reg[r] == 16'hFFFF) n_wrap = 1'b1;
                    n_reg[r] = 16'((int'(m_reg[r]) + 1) % 65536);
                end else begin
                    if (m_reg[r] == 16'h0000) n_wrap = 1'b1;
                    n_reg[r] = 16'((int'(m_reg[r]) + 65535) % 65536);
                end
            end
        end
        if (!rst_n) n_wrap = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < NUM_REGS; k++) begin
            bus.out_sel = 2'(k);
            #1;
            check($sformatf("%s RegOut r%0d", tag, k), 32'(bus.RegOut), 32'(m_reg[k]));
            for (int ln = 0; ln < 2; ln++) begin
                bus.rd_sel  = 2'(k);
                bus.rd_lane = 1'(ln);
                #1;
                check($sformatf("%s MainBusOut r%0d l%0d", tag, k, ln),
                      32'(bus.MainBusOut), 32'(m_reg[k][8*ln +: 8]));
            end
        end
    endtask

    // Apply the currently driven operations for one clock edge, then check.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_REGS; r++) begin
            m_reg[r] = n_reg[r];
`ifdef XFER_SHADOW_EN
            m_shadow[r] = n_shadow[r];
`endif
        end
        m_wrap = n_wrap;
        check({tag, " wrap"}, 32'(bus.wrap), 32'(m_wrap));
        idle();
        sweep(tag);
    endtask

    task automatic peek(input int k, input string tag, input logic [15:0] exp);
        bus.out_sel = 2'(k);
        #1;
        check(tag, 32'(bus.RegOut), 32'(exp));
    endtask

    function automatic logic [15:0] pick_word();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'hFFFE;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        for (int r = 0; r < NUM_REGS; r++) begin
            m_reg[r] = 16'h0000;
`ifdef XFER_SHADOW_EN
            m_shadow[r] = 8'h00;
`endif
        end
        m_wrap = 1'b0;
        idle();
        bus.xfer_sel = '0; bus.XferBusIn = '0;
        bus.main_sel = '0; bus.main_lane = '0; bus.MainBusIn = '0;
        bus.step_sel = '0; bus.out_sel = '0; bus.rd_sel = '0; bus.rd_lane = '0;

        rst_n = 1'b0;
        cycle("reset");

        // Byte assembly of 16'hDEAD in R1.
`ifdef XFER_SHADOW_EN
        op_byte(1, 0, 8'hAD); cycle("lane0");
        peek(1, "shadow hold", 16'h0000);
        op_byte(1, 1, 8'hDE); cycle("lane1");
        peek(1, "shadow commit", 16'hDEAD);
`else
        op_byte(1, 1, 8'hDE); cycle("lane1");
        peek(1, "lane1 only", 16'hDE00);
        op_byte(1, 0, 8'hAD); cycle("lane0");
        peek(1, "assembled", 16'hDEAD);
`endif

        // Transfer beats byte load on the same register.
        op_xfer(2, 16'hCAFE); op_byte(2, 0, 8'h11); cycle("xfer wins");
        peek(2, "xfer wins r2", 16'hCAFE);
        peek(3, "xfer wins r3", 16'h0000);

        // Increment wrap then decrement wrap on R0.
        op_xfer(0, 16'hFFFF); cycle("r0 ones");
        op_step(0, 1, 0); cycle("inc wrap");
        peek(0, "inc wrap r0", 16'h0000);
        check("inc wrap pulse", 32'(bus.wrap), 32'd1);
        cycle("after inc wrap");
        check("inc wrap cleared", 32'(bus.wrap), 32'd0);
        op_step(0, 0, 1); cycle("dec wrap");
        peek(0, "dec wrap r0", 16'hFFFF);
        check("dec wrap pulse", 32'(bus.wrap), 32'd1);
        cycle("after dec wrap");

        // Independent operations on three registers in one edge.
        op_xfer(3, 16'h0009); cycle("r3 nine");
        op_xfer(0, 16'h1234); op_byte(1, 1, 8'h56); op_step(3, 1, 0); cycle("parallel");
        peek(0, "parallel r0", 16'h1234);
        peek(3, "parallel r3", 16'h000A);
        bus.rd_sel = 2'd1; bus.rd_lane = 1'b1; #1;
        check("parallel r1 hi", 32'(bus.MainBusOut), 32'h56);

        // Simultaneous inc/dec and a step suppressed by a transfer.
        op_xfer(3, 16'h0005); cycle("r3 five");
        op_step(3, 1, 1); cycle("inc+dec");
        peek(3, "inc+dec r3", 16'h0005);
        check("inc+dec wrap", 32'(bus.wrap), 32'd0);
        op_xfer(3, 16'hFFFF); cycle("r3 ones");
        op_xfer(3, 16'h1111); op_step(3, 1, 0); cycle("xfer over inc");
        peek(3, "xfer over inc r3", 16'h1111);
        check("xfer over inc wrap", 32'(bus.wrap), 32'd0);

        // Reset overrides a concurrent transfer load.
        rst_n = 1'b0; op_xfer(1, 16'hBEEF); cycle("mid reset");
        peek(1, "mid reset r1", 16'h0000);

        // Randomized operation mix.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 2) == 0)
                op_xfer($urandom_range(0, 3), pick_word());
            if ($urandom_range(0, 2) == 0)
                op_byte($urandom_range(0, 3), $urandom_range(0, 1), 8'($urandom));
            if ($urandom_range(0, 1) == 0)
                op_step($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
